// File: rtl/mod_barrett_red.sv
// Barrett reducer: r = a mod m for a 2*WIDTH-bit operand, modulus/constant loaded at runtime.
// A single (WIDTH+1)x(WIDTH+1) multiplier is shared by the quotient-estimate and q3*m steps.
module mod_barrett_red #(
    parameter int WIDTH = 256
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_load,
    input  logic [WIDTH-1:0]   cfg_m,
    input  logic [WIDTH:0]     cfg_mu,
    output logic               cfg_valid,
    output logic               cfg_err,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2*WIDTH-1:0] in_a,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_r
);
    typedef enum logic [2:0] {S_IDLE, S_MUL1, S_MUL2, S_CORR, S_OUT} state_t;

    state_t               state_q;
    logic [WIDTH-1:0]     m_q;
    logic [WIDTH:0]       mu_q;
    logic [2*WIDTH-1:0]   a_q;
    logic [WIDTH:0]       q3_q;
    logic [WIDTH+1:0]     t_q;
    logic                 cfg_valid_q, cfg_err_q, out_valid_q;
    logic [WIDTH-1:0]     out_r_q;

    logic [WIDTH:0]       mul_a, mul_b;
    logic [2*WIDTH+1:0]   prod;
    logic [WIDTH+1:0]     m_x, r0, r1, r2;
    logic [WIDTH-1:0]     r_d;

    always_comb begin
        mul_a = a_q[2*WIDTH-1:WIDTH-1];
        mul_b = mu_q;
        if (state_q == S_MUL2) begin
            mul_a = q3_q;
            mul_b = {1'b0, m_q};
        end
        prod = {{(WIDTH+1){1'b0}}, mul_a} * {{(WIDTH+1){1'b0}}, mul_b};
    end

    // The true remainder a - q3*m can reach 3m-1, so keep WIDTH+2 bits end to end.
    always_comb begin
        m_x = {2'b00, m_q};
        r0  = a_q[WIDTH+1:0] - t_q;
        r1  = r0 - m_x;
        r2  = r1 - m_x;
        if (r0 < m_x)      r_d = r0[WIDTH-1:0];
        else if (r1 < m_x) r_d = r1[WIDTH-1:0];
        else               r_d = r2[WIDTH-1:0];
    end

    assign in_ready  = (state_q == S_IDLE) & cfg_valid_q & ~cfg_load;
    assign cfg_valid = cfg_valid_q;
    assign cfg_err   = cfg_err_q;
    assign out_valid = out_valid_q;
    assign out_r     = out_r_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            m_q         <= '0;
            mu_q        <= '0;
            a_q         <= '0;
            q3_q        <= '0;
            t_q         <= '0;
            cfg_valid_q <= 1'b0;
            cfg_err_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_r_q     <= '0;
        end else begin
            cfg_err_q <= 1'b0;
            if (cfg_load) begin
                if (state_q == S_IDLE && cfg_m[WIDTH-1]) begin
                    m_q         <= cfg_m;
                    mu_q        <= cfg_mu;
                    cfg_valid_q <= 1'b1;
                end else begin
                    cfg_err_q <= 1'b1;
                end
            end
            case (state_q)
                S_IDLE: if (in_valid && in_ready) begin
                    a_q     <= in_a;
                    state_q <= S_MUL1;
                end
                S_MUL1: begin
                    q3_q    <= prod[2*WIDTH+1:WIDTH+1];
                    state_q <= S_MUL2;
                end
                S_MUL2: begin
                    t_q     <= prod[WIDTH+1:0];
                    state_q <= S_CORR;
                end
                S_CORR: begin
                    out_r_q     <= r_d;
                    out_valid_q <= 1'b1;
                    state_q     <= S_OUT;
                end
                S_OUT: if (out_ready) begin
                    out_valid_q <= 1'b0;
                    state_q     <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule
